demux_16_seq: RTL and testbench
===============================

Name: demux_16_seq

Overview:
- Registered 1-to-16 write distributor: the write-side counterpart of the 16:1 read-select path.
- Accepts a stream of words over a valid/ready handshake and steers each word into one of 16 output lanes.
- The lane is chosen by an explicit address or by an internal auto-incrementing pointer.
- Each lane holds its word until the consumer acknowledges it; the block stalls the producer rather than overwrite unconsumed data.

Parameters:
WIDTH, 32, data word width in bits

Ports:
clock  input  1  system clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset
in_valid  input  1  producer has a word on in_data
in_ready  output  1  block accepts the word this cycle (combinational)
in_data  input  WIDTH  word to write
in_addr  input  4  target lane when addr_mode=0
addr_mode  input  1  0 = explicit address (in_addr), 1 = auto-increment pointer
clear  input  1  synchronous restart: pointer and lane-valid flags to 0
lane_ack  input  16  per-lane consumer acknowledge; bit i releases lane i
out_data  output  16*WIDTH  lane i occupies bits [i*WIDTH +: WIDTH]
lane_valid  output  16  lane i holds an unacknowledged word
out_strobe  output  16  one-hot, one-cycle pulse marking the lane just written
frame_done  output  1  one-cycle pulse after lane 15 is written in auto mode
ptr  output  4  current auto-increment pointer

Behaviour:
- Reset (reset=0, asynchronous, independent of clock): out_data=0, lane_valid=0, out_strobe=0, frame_done=0, ptr=0.
  - Reset takes effect immediately, even mid-frame.
  - After release, the first accept occurs no earlier than the next rising edge.
- Target lane: target = addr_mode ? ptr : in_addr.
- in_ready = ~clear & (~lane_valid[target] | lane_ack[target]); combinational, with no dependence on in_valid.
- Accept: in_valid & in_ready at a rising edge. At that edge:
  - out_data lane[target] <= in_data.
  - lane_valid[target] <= 1.
  - out_strobe <= one-hot(target); all other bits 0.
  - If addr_mode=1: ptr <= ptr+1, wrapping 15 -> 0, and frame_done <= (ptr==15).
  - If addr_mode=0: ptr holds and frame_done <= 0.
- Latency: written data, lane_valid, and out_strobe are visible in the cycle after the accepting edge.
  - out_strobe and frame_done are 0 in every cycle that does not follow an accept.
- Release: at each edge, for each i with lane_ack[i]=1, lane_valid[i] <= 0.
  - Exception: if the same edge writes lane i, lane_valid[i] stays 1 (the write wins).
  - lane_ack on a lane that is not valid is ignored.
  - Acks do not modify out_data; a released lane keeps its last word.
- Multiple acks may occur in one cycle; at most one write occurs per cycle.
- clear=1 at an edge:
  - ptr <= 0, lane_valid <= 0, out_strobe <= 0, frame_done <= 0.
  - No accept occurs, because in_ready is forced to 0.
  - out_data is retained.
  - clear takes priority over lane_ack and over any write.
- Mode switch: ptr is retained across addr_mode changes. Explicit-mode writes never move ptr, even when in_addr equals ptr.
- Stall: if in_valid=1 and in_ready=0, the producer must hold in_data/in_addr. The block keeps no internal copy of the stalled word.

Test Plan:
1. Reset: run auto mode to ptr=7, then pull reset low between edges.
   -> out_data=0, lane_valid=0, ptr=0, out_strobe=0 immediately.
   -> After release, a write of 0xA5 lands in lane 0.
2. Auto frame: addr_mode=1, lane_ack=16'hFFFF, stream 0x100..0x10F on consecutive cycles.
   -> lane i = 0x100+i.
   -> out_strobe = 1<<i in the cycle after each accept.
   -> frame_done high exactly one cycle, after the 0x10F accept; ptr=0.
3. Backpressure: addr_mode=1, no acks, 16 writes, then a 17th word 0x200.
   -> in_ready=0 and lane 0 still holds its first word.
   -> Assert lane_ack[0] for one cycle: 0x200 accepted that edge, lane_valid[0] stays 1, ptr=1.
4. Explicit mode: in_addr=5, write 0xDEAD; next cycle in_addr=5, 0xBEEF, no ack.
   -> in_ready=0, lane 5 = 0xDEAD.
   -> With lane_ack[5]=1: accepted, lane 5 = 0xBEEF, ptr unchanged.
5. Clear: ptr=4, lane_valid=16'h000F, in_valid=1, clear=1.
   -> No write, ptr=0, lane_valid=0, out_data lanes 0-3 retained, out_strobe=0.
6. Mode switch: auto writes to lanes 0-2; switch to explicit and write lane 9; switch back to auto and write 0x77.
   -> 0x77 lands in lane 3, ptr=4, lane 9 valid.

Source files
------------

// File: rtl/demux_16_seq.sv
// Registered 1-to-16 write distributor: steers a valid/ready word stream into
// sixteen held lanes, addressed explicitly or by an auto-incrementing pointer.
module demux_16_seq #(
   parameter int WIDTH = 32
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [WIDTH-1:0]      in_data,
   input  logic [3:0]            in_addr,
   input  logic                  addr_mode,
   input  logic                  clear,
   input  logic [15:0]           lane_ack,
   output logic [16*WIDTH-1:0]   out_data,
   output logic [15:0]           lane_valid,
   output logic [15:0]           out_strobe,
   output logic                  frame_done,
   output logic [3:0]            ptr
);

   function automatic logic [15:0] lane_onehot(input logic [3:0] idx);
      lane_onehot = 16'd1 << idx;
   endfunction

   logic [WIDTH-1:0] lane_r [16];
   logic [15:0]      lane_valid_r;
   logic [15:0]      strobe_r;
   logic             frame_done_r;
   logic [3:0]       ptr_r;

   logic [3:0]       target_s;
   logic             ready_s;
   logic             accept_s;
   logic [15:0]      target_oh_s;

   // Lane selection and acceptance; an ack on the target lane frees it in the same cycle.
   always_comb begin
      target_s    = 4'd0;
      ready_s     = 1'b0;
      accept_s    = 1'b0;
      target_oh_s = 16'd0;
      if (addr_mode) begin
         target_s = ptr_r;
      end else begin
         target_s = in_addr;
      end
      ready_s     = ~clear & (~lane_valid_r[target_s] | lane_ack[target_s]);
      accept_s    = in_valid & ready_s;
      target_oh_s = lane_onehot(target_s);
   end

   // Lane storage, valid flags, pointer and pulse outputs.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 16; i++) begin
            lane_r[i] <= '0;
         end
         lane_valid_r <= 16'd0;
         strobe_r     <= 16'd0;
         frame_done_r <= 1'b0;
         ptr_r        <= 4'd0;
      end else if (clear) begin
         // Lane contents deliberately survive a clear; only bookkeeping restarts.
         lane_valid_r <= 16'd0;
         strobe_r     <= 16'd0;
         frame_done_r <= 1'b0;
         ptr_r        <= 4'd0;
      end else begin
         if (accept_s) begin
            lane_r[target_s] <= in_data;
            lane_valid_r     <= (lane_valid_r & ~lane_ack) | target_oh_s;
            strobe_r         <= target_oh_s;
            frame_done_r     <= addr_mode & (ptr_r == 4'd15);
            if (addr_mode) begin
               ptr_r <= ptr_r + 4'd1;
            end else begin
               ptr_r <= ptr_r;
            end
         end else begin
            lane_valid_r <= lane_valid_r & ~lane_ack;
            strobe_r     <= 16'd0;
            frame_done_r <= 1'b0;
            ptr_r        <= ptr_r;
         end
      end
   end

   genvar g;
   generate
      for (g = 0; g < 16; g++) begin : g_lane
         assign out_data[g*WIDTH +: WIDTH] = lane_r[g];
      end
   endgenerate

   assign in_ready   = ready_s;
   assign lane_valid = lane_valid_r;
   assign out_strobe = strobe_r;
   assign frame_done = frame_done_r;
   assign ptr        = ptr_r;

endmodule

// File: tb/tb_demux_16_seq.sv
// Self-checking bench for demux_16_seq: directed scenarios plus random traffic
// compared against an array-based reference model.
module tb_demux_16_seq;

   localparam int WIDTH = 32;

   logic                clock;
   logic                reset;
   logic                in_valid;
   logic                in_ready;
   logic [WIDTH-1:0]    in_data;
   logic [3:0]          in_addr;
   logic                addr_mode;
   logic                clear;
   logic [15:0]         lane_ack;
   logic [16*WIDTH-1:0] out_data;
   logic [15:0]         lane_valid;
   logic [15:0]         out_strobe;
   logic                frame_done;
   logic [3:0]          ptr;

   demux_16_seq #(.WIDTH(WIDTH)) dut (
      .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_addr(in_addr), .addr_mode(addr_mode), .clear(clear),
      .lane_ack(lane_ack), .out_data(out_data), .lane_valid(lane_valid),
      .out_strobe(out_strobe), .frame_done(frame_done), .ptr(ptr)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int errors = 0;
   int checks = 0;

   // reference model state
   logic [WIDTH-1:0] m_lane [16];
   bit               m_valid [16];
   int               m_strobe_lane;   // -1 when no strobe expected
   bit               m_fd;
   int               m_ptr;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [15:0] exp_valid_vec();
      logic [15:0] v;
      v = 16'd0;
      for (int i = 0; i < 16; i++) v[i] = m_valid[i];
      return v;
   endfunction

   function automatic logic [15:0] exp_strobe_vec();
      logic [15:0] v;
      v = 16'd0;
      if (m_strobe_lane >= 0) v[m_strobe_lane] = 1'b1;
      return v;
   endfunction

   task automatic check_outputs(input string tag);
      for (int i = 0; i < 16; i++) begin
         chk($sformatf("%s_lane%0d", tag, i), 64'(out_data[i*WIDTH +: WIDTH]), 64'(m_lane[i]));
      end
      chk({tag, "_valid"},  64'(lane_valid), 64'(exp_valid_vec()));
      chk({tag, "_strobe"}, 64'(out_strobe), 64'(exp_strobe_vec()));
      chk({tag, "_fdone"},  64'(frame_done), 64'(m_fd));
      chk({tag, "_ptr"},    64'(ptr),        64'(m_ptr));
   endtask

   task automatic model_reset();
      for (int i = 0; i < 16; i++) begin
         m_lane[i]  = '0;
         m_valid[i] = 1'b0;
      end
      m_strobe_lane = -1;
      m_fd          = 1'b0;
      m_ptr         = 0;
   endtask

   // One clock: check in_ready against the model, advance the edge, then check all outputs.
   task automatic tick(input string tag);
      int tgt;
      bit rdy;
      bit acc;
      #1;
      tgt = addr_mode ? m_ptr : int'(in_addr);
      rdy = !clear && (!m_valid[tgt] || lane_ack[tgt]);
      chk({tag, "_ready"}, 64'(in_ready), 64'(rdy));
      acc = in_valid && rdy;
      @(posedge clock);
      if (clear) begin
         for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
         m_ptr         = 0;
         m_strobe_lane = -1;
         m_fd          = 1'b0;
      end else begin
         for (int i = 0; i < 16; i++) if (lane_ack[i]) m_valid[i] = 1'b0;
         if (acc) begin
            m_lane[tgt]   = in_data;
            m_valid[tgt]  = 1'b1;
            m_strobe_lane = tgt;
            m_fd          = addr_mode && (m_ptr == 15);
            if (addr_mode) m_ptr = (m_ptr + 1) % 16;
         end else begin
            m_strobe_lane = -1;
            m_fd          = 1'b0;
         end
      end
      #1;
      check_outputs(tag);
   endtask

   task automatic drive(input bit v, input bit mode, input logic [3:0] addr,
                        input logic [WIDTH-1:0] data, input logic [15:0] ack,
                        input bit clr, input string tag);
      in_valid  = v;
      addr_mode = mode;
      in_addr   = addr;
      in_data   = data;
      lane_ack  = ack;
      clear     = clr;
      tick(tag);
   endtask

   task automatic idle(input string tag);
      drive(1'b0, 1'b0, 4'd0, '0, 16'd0, 1'b0, tag);
   endtask

   task automatic do_clear(input string tag);
      drive(1'b0, 1'b0, 4'd0, '0, 16'd0, 1'b1, tag);
   endtask

   initial begin
      reset = 1'b0; in_valid = 1'b0; in_data = '0; in_addr = 4'd0;
      addr_mode = 1'b0; clear = 1'b0; lane_ack = 16'd0;
      model_reset();
      repeat (2) @(posedge clock);
      #1;
      check_outputs("rst");
      reset = 1'b1;
      idle("post_rst");

      // 1. async reset mid-frame
      for (int i = 0; i < 7; i++) drive(1'b1, 1'b1, 4'd0, 32'h50 + i, 16'd0, 1'b0, "t1_fill");
      chk("t1_ptr7", 64'(ptr), 64'd7);
      #2;
      reset = 1'b0;
      #1;
      model_reset();
      check_outputs("t1_async");
      #1;
      reset = 1'b1;
      drive(1'b1, 1'b1, 4'd0, 32'hA5, 16'd0, 1'b0, "t1_first");
      chk("t1_lane0_a5", 64'(out_data[0 +: WIDTH]), 64'h00A5);

      // 2. auto frame with continuous acks
      do_clear("t2_clr");
      for (int i = 0; i < 16; i++) begin
         drive(1'b1, 1'b1, 4'd0, 32'h100 + i, 16'hFFFF, 1'b0, "t2_wr");
         chk("t2_strobe", 64'(out_strobe), 64'(16'd1 << i));
         chk("t2_fdone", 64'(frame_done), (i == 15) ? 64'd1 : 64'd0);
      end
      chk("t2_ptr0", 64'(ptr), 64'd0);
      idle("t2_after");
      chk("t2_fd_low", 64'(frame_done), 64'd0);

      // 3. backpressure
      do_clear("t3_clr");
      for (int i = 0; i < 16; i++) drive(1'b1, 1'b1, 4'd0, 32'h300 + i, 16'd0, 1'b0, "t3_wr");
      drive(1'b1, 1'b1, 4'd0, 32'h200, 16'd0, 1'b0, "t3_stall");
      chk("t3_lane0_kept", 64'(out_data[0 +: WIDTH]), 64'h300);
      #1;
      chk("t3_ready_low", 64'(in_ready), 64'd0);
      drive(1'b1, 1'b1, 4'd0, 32'h200, 16'h0001, 1'b0, "t3_ack");
      chk("t3_lane0_new", 64'(out_data[0 +: WIDTH]), 64'h200);
      chk("t3_valid0", 64'(lane_valid[0]), 64'd1);
      chk("t3_ptr1", 64'(ptr), 64'd1);

      // 4. explicit mode
      do_clear("t4_clr");
      drive(1'b1, 1'b1, 4'd0, 32'h11, 16'd0, 1'b0, "t4_auto");
      drive(1'b1, 1'b1, 4'd0, 32'h12, 16'd0, 1'b0, "t4_auto");
      drive(1'b1, 1'b0, 4'd5, 32'hDEAD, 16'd0, 1'b0, "t4_dead");
      drive(1'b1, 1'b0, 4'd5, 32'hBEEF, 16'd0, 1'b0, "t4_stall");
      chk("t4_lane5_dead", 64'(out_data[5*WIDTH +: WIDTH]), 64'hDEAD);
      drive(1'b1, 1'b0, 4'd5, 32'hBEEF, 16'h0020, 1'b0, "t4_ack");
      chk("t4_lane5_beef", 64'(out_data[5*WIDTH +: WIDTH]), 64'hBEEF);
      chk("t4_ptr2", 64'(ptr), 64'd2);

      // 5. clear wins over a pending write
      do_clear("t5_clr");
      for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 4'd0, 32'h400 + i, 16'd0, 1'b0, "t5_wr");
      chk("t5_valid_f", 64'(lane_valid), 64'h000F);
      drive(1'b1, 1'b1, 4'd0, 32'h4FF, 16'd0, 1'b1, "t5_clear");
      chk("t5_ptr0", 64'(ptr), 64'd0);
      chk("t5_valid0", 64'(lane_valid), 64'd0);
      chk("t5_lane3_kept", 64'(out_data[3*WIDTH +: WIDTH]), 64'h403);

      // 6. mode switch keeps the pointer
      for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 4'd0, 32'h600 + i, 16'd0, 1'b0, "t6_auto");
      drive(1'b1, 1'b0, 4'd9, 32'h699, 16'd0, 1'b0, "t6_expl");
      drive(1'b1, 1'b1, 4'd0, 32'h77, 16'd0, 1'b0, "t6_back");
      chk("t6_lane3", 64'(out_data[3*WIDTH +: WIDTH]), 64'h77);
      chk("t6_ptr4", 64'(ptr), 64'd4);
      chk("t6_valid9", 64'(lane_valid[9]), 64'd1);

      // random traffic
      for (int n = 0; n < 400; n++) begin
         logic [15:0] ack;
         ack = ($urandom_range(0, 2) == 0) ? 16'($urandom) : 16'd0;
         drive(1'($urandom_range(0, 3) != 0), 1'($urandom), 4'($urandom),
               32'($urandom), ack, ($urandom_range(0, 40) == 0), "rnd");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
